lvds_capture_ctrl: RTL and testbench

// Capture sequencer for the serial LVDS receive path. Detects frame start on LVDS_VS,

---
 rtl/lvds_capture_ctrl_pkg.sv | 35 +++
 rtl/lvds_capture_ctrl_tgl_sync.sv | 36 +++
 rtl/lvds_capture_ctrl.sv | 125 ++++++++++++
 tb/tb_lvds_capture_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_capture_ctrl_pkg.sv
// Shared definitions for the LVDS capture sequencer: FSM encodings, STATE
// field positions, default geometry and the ping-pong bank selection rule.
package lvds_capture_ctrl_pkg;

   localparam int WORDS_PER_FRAME_DEF = 256;
   localparam int ADDR_W_DEF          = 9;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_WAIT_SOF = 3'd2,
      ST_SHIFT    = 3'd3,
      ST_DROP     = 3'd4,
      ST_DONE     = 3'd5
   } cap_state_t;

   localparam int STATE_OVR_BIT  = 7;
   localparam int STATE_LAST_BIT = 6;
   localparam int STATE_FULL_LSB = 4;
   localparam int STATE_FSM_LSB  = 0;

   // Returns {ok, bank}: the preferred bank if free, else the other one if free.
   function automatic logic [1:0] pick_bank(input logic [1:0] full, input logic pref);
      logic [1:0] res;
      if (!full[pref]) begin
         res = {1'b1, pref};
      end else if (!full[~pref]) begin
         res = {1'b1, ~pref};
      end else begin
         res = 2'b00;
      end
      return res;
   endfunction

endpackage

// File: rtl/lvds_capture_ctrl_tgl_sync.sv
// Two-flop synchroniser for signals entering the LVDS_CLK domain; with EDGE set
// it emits a one-cycle pulse for every toggle of the input, else the level.
module tgl_sync #(
   parameter bit EDGE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   if (EDGE) begin : g_edge
      logic [2:0] sync_r;
      // Synchroniser chain plus one history flop for toggle detection
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_r <= 3'b000;
         end else begin
            sync_r <= {sync_r[1:0], d};
         end
      end
      assign q = sync_r[2] ^ sync_r[1];
   end else begin : g_level
      logic [1:0] sync_r;
      // Plain synchroniser chain for quasi-static levels
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_r <= 2'b00;
         end else begin
            sync_r <= {sync_r[0], d};
         end
      end
      assign q = sync_r[1];
   end

endmodule

// File: rtl/lvds_capture_ctrl.sv
// Capture sequencer: frame detection on LVDS_VS, MSB-first word assembly and
// ping-pong writes into the dual-bank receive SRAM with full/overrun status.
module lvds_capture_ctrl
   import lvds_capture_ctrl_pkg::*;
#(
   parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
   parameter int ADDR_W          = ADDR_W_DEF
) (
   input  logic              LVDS_CLK,
   input  logic              RSTn,
   input  logic              LVDS_VS,
   input  logic              LVDS_DATA,
   input  logic              CAP_EN,
   input  logic [1:0]        CLR_TGL,
   input  logic              OVR_CLR_TGL,
   output logic              BUF_WEN,
   output logic [ADDR_W-1:0] BUF_WADDR,
   output logic [31:0]       BUF_WD,
   output logic [1:0]        BANK_FULL,
   output logic              LAST_BANK,
   output logic [ADDR_W-1:0] FRAME_LEN,
   output logic [7:0]        STATE
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_FRAME - 1);

   logic              cap_en;
   logic [1:0]        clr_pulse;
   logic              ovr_clr;
   cap_state_t        state;
   logic              bank;
   logic              pref;
   logic              overrun;
   logic [ADDR_W-1:0] wcnt;
   logic [4:0]        bit_cnt;
   logic [31:0]       shreg;
   logic [1:0]        pick;

   tgl_sync #(.EDGE(1'b0)) u_cap_sync (.clk(LVDS_CLK), .rst_n(RSTn), .d(CAP_EN), .q(cap_en));
   tgl_sync #(.EDGE(1'b1)) u_ovr_sync (.clk(LVDS_CLK), .rst_n(RSTn), .d(OVR_CLR_TGL), .q(ovr_clr));

   for (genvar i = 0; i < 2; i++) begin : g_clr
      tgl_sync #(.EDGE(1'b1)) u_clr_sync (.clk(LVDS_CLK), .rst_n(RSTn), .d(CLR_TGL[i]), .q(clr_pulse[i]));
   end

   assign pick  = pick_bank(BANK_FULL, pref);
   assign STATE = {overrun, LAST_BANK, BANK_FULL, 1'b0, state};

   // Capture FSM, word assembly, SRAM write port and bank status
   always_ff @(posedge LVDS_CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= ST_IDLE;
         bank      <= 1'b0;
         pref      <= 1'b0;
         overrun   <= 1'b0;
         wcnt      <= '0;
         bit_cnt   <= 5'd0;
         shreg     <= 32'd0;
         BUF_WEN   <= 1'b0;
         BUF_WADDR <= '0;
         BUF_WD    <= 32'd0;
         BANK_FULL <= 2'b00;
         LAST_BANK <= 1'b0;
         FRAME_LEN <= '0;
      end else begin
         BUF_WEN   <= 1'b0;
         BANK_FULL <= BANK_FULL & ~clr_pulse;
         overrun   <= overrun & ~ovr_clr;
         if (!cap_en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ARM;
               ST_ARM: begin
                  if (LVDS_VS) state <= ST_WAIT_SOF;
               end
               ST_WAIT_SOF: begin
                  if (!LVDS_VS) begin
                     if (pick[1]) begin
                        bank    <= pick[0];
                        shreg   <= {31'd0, LVDS_DATA};
                        bit_cnt <= 5'd1;
                        wcnt    <= '0;
                        state   <= ST_SHIFT;
                     end else begin
                        overrun <= 1'b1;
                        state   <= ST_DROP;
                     end
                  end
               end
               ST_SHIFT: begin
                  // A rising VS ends the frame; any partially assembled word is lost
                  if (LVDS_VS) begin
                     state <= ST_DONE;
                  end else begin
                     shreg   <= {shreg[30:0], LVDS_DATA};
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd31) begin
                        BUF_WEN   <= 1'b1;
                        BUF_WD    <= {shreg[30:0], LVDS_DATA};
                        BUF_WADDR <= {bank, wcnt[ADDR_W-2:0]};
                        wcnt      <= wcnt + ADDR_W'(1);
                        if (wcnt == LAST_WORD) state <= ST_DONE;
                     end
                  end
               end
               ST_DROP: begin
                  if (LVDS_VS) state <= ST_WAIT_SOF;
               end
               ST_DONE: begin
                  if (wcnt != '0) begin
                     BANK_FULL <= (BANK_FULL & ~clr_pulse) | (2'b01 << bank);
                     LAST_BANK <= bank;
                     FRAME_LEN <= wcnt;
                     pref      <= ~bank;
                  end
                  state <= ST_ARM;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// Self-checking bench: frame-level model predicts every SRAM write and the
// bank/overrun status; random frames, releases and reset/enable corner cases.
module tb_lvds_capture_ctrl;

   localparam int WPF = 256;
   localparam int AW  = 9;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          vs = 1'b1;
   logic          din = 1'b0;
   logic          cap_en = 1'b0;
   logic [1:0]    clr_tgl = 2'b00;
   logic          ovr_clr_tgl = 1'b0;
   logic          buf_wen;
   logic [AW-1:0] buf_waddr;
   logic [31:0]   buf_wd;
   logic [1:0]    bank_full;
   logic          last_bank;
   logic [AW-1:0] frame_len;
   logic [7:0]    state;

   always #5 clk = ~clk;

   lvds_capture_ctrl #(.WORDS_PER_FRAME(WPF), .ADDR_W(AW)) dut (
      .LVDS_CLK(clk), .RSTn(rstn), .LVDS_VS(vs), .LVDS_DATA(din), .CAP_EN(cap_en),
      .CLR_TGL(clr_tgl), .OVR_CLR_TGL(ovr_clr_tgl), .BUF_WEN(buf_wen),
      .BUF_WADDR(buf_waddr), .BUF_WD(buf_wd), .BANK_FULL(bank_full),
      .LAST_BANK(last_bank), .FRAME_LEN(frame_len), .STATE(state)
   );

   int checks = 0;
   int failures = 0;

   // Model: expected writes and frame-level status
   logic [AW-1:0] exp_addr_q[$];
   logic [31:0]   exp_data_q[$];
   logic [1:0]    m_full = 2'b00;
   logic          m_pref = 1'b0;
   logic          m_last = 1'b0;
   logic          m_ovr = 1'b0;
   int            m_len = 0;
   logic [AW-1:0] last_waddr = '0;
   logic [31:0]   last_wd = 32'd0;
   bit            frame_bits[0:8400];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every DUT write must be the next one the model predicts
   always @(posedge clk) begin
      #1;
      if (rstn && buf_wen) begin
         if (exp_addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h:%0h required=no write", buf_waddr, buf_wd);
         end else begin
            check("waddr", buf_waddr, exp_addr_q.pop_front());
            check("wdata", buf_wd, exp_data_q.pop_front());
         end
         last_waddr = buf_waddr;
         last_wd    = buf_wd;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fill_index();
      for (int w = 0; w < WPF; w++)
         for (int b = 0; b < 32; b++)
            frame_bits[w*32+b] = ((w >> (31 - b)) & 1) != 0;
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) frame_bits[i] = ($urandom_range(0, 1) == 1);
   endtask

   // Predict the frame, drive it with VS low for nbits cycles, then check status
   task automatic run_frame(input int nbits);
      int nwords;
      int bank;
      bit ok;
      logic [31:0] data;
      nwords = nbits / 32;
      if (nwords > WPF) nwords = WPF;
      ok = 1'b1;
      if (!m_full[m_pref]) bank = int'(m_pref);
      else if (!m_full[!m_pref]) bank = int'(!m_pref);
      else ok = 1'b0;
      if (ok) begin
         for (int k = 0; k < nwords; k++) begin
            data = 32'd0;
            for (int b = 0; b < 32; b++) data = {data[30:0], frame_bits[k*32+b]};
            exp_addr_q.push_back(AW'((bank << (AW - 1)) | k));
            exp_data_q.push_back(data);
         end
      end else begin
         m_ovr = 1'b1;
      end
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         vs  = 1'b0;
         din = frame_bits[i];
      end
      @(negedge clk);
      vs  = 1'b1;
      din = $urandom_range(0, 1) == 1;
      cyc(5);
      if (ok && nwords > 0) begin
         m_full[bank] = 1'b1;
         m_last = bank[0];
         m_len  = nwords;
         m_pref = !bank[0];
      end
      check("writes_done", exp_addr_q.size(), 0);
      check("bank_full", bank_full, m_full);
      check("last_bank", last_bank, m_last);
      check("frame_len", frame_len, m_len);
      check("overrun", state[7], m_ovr);
   endtask

   task automatic release_bank(input int b);
      @(negedge clk);
      clr_tgl[b] = ~clr_tgl[b];
      m_full[b]  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("release", bank_full, m_full);
   endtask

   task automatic ovr_clear();
      @(negedge clk);
      ovr_clr_tgl = ~ovr_clr_tgl;
      m_ovr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ovr_clear", state[7], 1'b0);
   endtask

   task automatic model_reset();
      m_full = 2'b00;
      m_pref = 1'b0;
      m_last = 1'b0;
      m_ovr  = 1'b0;
      m_len  = 0;
   endtask

   initial begin
      #1_500_000;
      checks++;
      failures++;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      cyc(3);
      check("rst_wen", buf_wen, 1'b0);
      check("rst_state", state, 8'h00);
      check("rst_len", frame_len, 0);
      check("rst_addr", buf_waddr, 0);
      rstn   = 1'b1;
      cap_en = 1'b1;
      cyc(6);
      check("armed_state", state, 8'h02);

      // Full index frames into bank0 then bank1
      fill_index();
      run_frame(WPF * 32);
      check("f1_state", state, 8'h12);
      check("f1_last_addr", last_waddr, 9'h0FF);
      check("f1_last_data", last_wd, 32'd255);
      run_frame(WPF * 32);
      check("f2_state", state, 8'h72);
      check("f2_last_addr", last_waddr, 9'h1FF);

      // Both banks full: frame dropped, overrun flagged
      fill_random(300);
      run_frame(300);
      check("f3_state", state, 8'hF2);
      ovr_clear();
      check("f3_cleared", state, 8'h72);

      release_bank(0);
      fill_random(WPF * 32);
      run_frame(WPF * 32);
      check("f4_last_bank", last_bank, 1'b0);

      // Short frame: 100 bits gives 3 words, 4 bits dropped
      release_bank(1);
      release_bank(0);
      fill_random(100);
      run_frame(100);
      check("short_len", frame_len, 9'd3);
      check("short_last_addr", last_waddr, 9'h102);

      for (int it = 0; it < 15; it++) begin
         if ($urandom_range(0, 2) == 0) release_bank(int'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) ovr_clear();
         case ($urandom_range(0, 2))
            0: n = int'($urandom_range(0, 31));
            1: n = int'($urandom_range(1, 30)) * 32;
            default: n = int'($urandom_range(32, 1200));
         endcase
         fill_random(n);
         run_frame(n);
      end

      // Over-length frame: index stops at the last word of the bank
      release_bank(0);
      release_bank(1);
      fill_random(WPF * 32 + 40);
      run_frame(WPF * 32 + 40);

      // Reset mid-SHIFT: no writes until VS goes high then low again
      release_bank(0);
      release_bank(1);
      fill_random(50);
      for (int k = 0; k < 1; k++) begin
         logic [31:0] d;
         d = 32'd0;
         for (int b = 0; b < 32; b++) d = {d[30:0], frame_bits[b]};
         exp_addr_q.push_back(AW'((int'(m_pref) << (AW - 1))));
         exp_data_q.push_back(d);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         vs  = 1'b0;
         din = frame_bits[i];
      end
      @(negedge clk);
      rstn = 1'b0;
      model_reset();
      #1;
      check("midrst_queue", exp_addr_q.size(), 0);
      check("midrst_state", state, 8'h00);
      check("midrst_wen", buf_wen, 1'b0);
      cyc(2);
      rstn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         din = $urandom_range(0, 1) == 1;
      end
      vs = 1'b1;
      cyc(5);
      check("midrst_rearm", state, 8'h02);
      fill_random(200);
      run_frame(200);

      // CAP_EN raised while VS already low: wait for the next frame start
      cap_en = 1'b0;
      cyc(5);
      check("capoff_fsm", state[2:0], 3'd0);
      vs = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         din = $urandom_range(0, 1) == 1;
         if (i == 10) cap_en = 1'b1;
      end
      vs = 1'b1;
      cyc(5);
      fill_random(96);
      run_frame(96);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
